// File: rtl/ro_pkg.sv
// Shared FSM encoding and default parameters for the ring-oscillator frequency meter.
package ro_pkg;

  localparam int unsigned GateWDefault  = 16;
  localparam int unsigned CntWDefault   = 24;
  localparam int unsigned SettleDefault = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StMeasure = 2'd2,
    StDone    = 2'd3
  } ro_state_e;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for the asynchronous ring-oscillator output plus rising-edge detect.
module ro_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated edge counter for a ring oscillator: enable, settle, count over a CLK-cycle gate, report.
module ro_freq_meter
  import ro_pkg::*;
#(
  parameter int unsigned GATE_W = GateWDefault,
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned SETTLE = SettleDefault
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [GATE_W-1:0] GateCycles,
  input  logic              StressHold,
  input  logic              RoIn,
  output logic              Mode,
  output logic              Stress,
  output logic [CNT_W-1:0]  Count,
  output logic              Valid,
  output logic              Busy,
  output logic              Overflow
);

  localparam int unsigned      SetW    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SetW-1:0]  SetLast = (SETTLE == 0) ? '0 : SetW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  ro_state_e         state_q, state_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              stress_q, stress_d;
  logic              rise;

  ro_edge_sync u_edge_sync (
    .clk_i  (CLK),
    .rst_i  (RST),
    .d_i    (RoIn),
    .rise_o (rise)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    stress_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        stress_d = StressHold;
        if (Start) begin
          stress_d = 1'b0;
          count_d  = '0;
          ovf_d    = 1'b0;
          gate_d   = GateCycles;
          settle_d = '0;
          if (GateCycles == '0) begin
            state_d = StDone;
          end else if (SETTLE == 0) begin
            state_d = StMeasure;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        settle_d = settle_q + SetW'(1);
        if (settle_q == SetLast) state_d = StMeasure;
      end
      StMeasure: begin
        gate_d = gate_q - GATE_W'(1);
        // Saturate rather than wrap; Overflow records that an edge was lost.
        if (rise) begin
          if (count_q == CntMax) ovf_d = 1'b1;
          else                   count_d = count_q + CNT_W'(1);
        end
        if (gate_q == GATE_W'(1)) state_d = StDone;
      end
      StDone: begin
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      settle_q <= '0;
      gate_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      stress_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      stress_q <= stress_d;
    end
  end

  assign Mode     = (state_q == StSettle) || (state_q == StMeasure);
  assign Busy     = (state_q != StIdle);
  assign Stress   = stress_q;
  assign Count    = count_q;
  assign Valid    = valid_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: directed and random gates against an edge-count model of RoIn history.
module tb_ro_freq_meter;

  localparam int GW     = 16;
  localparam int SETTLE = 4;
  localparam int MAX24  = (1 << 24) - 1;
  localparam int MAX4   = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Start = 1'b0;
  logic [GW-1:0] GateCycles = '0;
  logic          StressHold = 1'b0;
  logic          RoIn = 1'b0;

  logic          Mode, Stress, Valid, Busy, Overflow;
  logic [23:0]   Count;
  logic          Mode4, Stress4, Valid4, Busy4, Overflow4;
  logic [3:0]    Count4;

  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  ro_period = 10;
  int  run_left = 0;
  int  cur_g = 0;
  logic ro_hist [0:8191];

  ro_freq_meter #(.GATE_W(GW), .CNT_W(24), .SETTLE(SETTLE)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start      (Start),
    .GateCycles (GateCycles),
    .StressHold (StressHold),
    .RoIn       (RoIn),
    .Mode       (Mode),
    .Stress     (Stress),
    .Count      (Count),
    .Valid      (Valid),
    .Busy       (Busy),
    .Overflow   (Overflow)
  );

  ro_freq_meter #(.GATE_W(GW), .CNT_W(4), .SETTLE(SETTLE)) u_dut_c4 (
    .CLK        (CLK),
    .RST        (RST),
    .Start      (Start),
    .GateCycles (GateCycles),
    .StressHold (StressHold),
    .RoIn       (RoIn),
    .Mode       (Mode4),
    .Stress     (Stress4),
    .Count      (Count4),
    .Valid      (Valid4),
    .Busy       (Busy4),
    .Overflow   (Overflow4)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // RoIn: square wave of ro_period, or random runs of 2..6 cycles per level when ro_period == 0.
  always @(negedge CLK) begin
    if (ro_period != 0) begin
      RoIn = ((cyc % ro_period) < (ro_period / 2));
    end else begin
      if (run_left == 0) begin
        RoIn = ~RoIn;
        run_left = $urandom_range(6, 2);
      end
      run_left = run_left - 1;
    end
    if (cyc < 8192) ro_hist[cyc] = RoIn;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (g=%0d): observed %0d expected %0d", tag, cur_g, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " main outputs"}, {26'd0, Mode, Stress, Valid, Busy, Overflow, |Count}, 32'd0);
    chk({tag, " c4 outputs"}, {26'd0, Mode4, Stress4, Valid4, Busy4, Overflow4, |Count4}, 32'd0);
  endtask

  task automatic run_meas(input int g, input bit inject);
    int t0, k, lim, done_k, vcnt, vcnt4, vk, edges, exp_vk;
    bit mode_ok, busy_ok, stress_ok;
    logic exp_mode;
    cur_g = g;
    @(negedge CLK);
    Start = 1'b1;
    GateCycles = GW'(g);
    t0 = cyc;
    lim = SETTLE + g + 8;
    done_k = (g == 0) ? 1 : SETTLE + g + 1;
    vcnt = 0; vcnt4 = 0; vk = -1;
    mode_ok = 1'b1; busy_ok = 1'b1; stress_ok = 1'b1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge CLK);
      Start = 1'b0;
      GateCycles = GW'($urandom);
      k = cyc - t0;
      if (inject && k == SETTLE + 1 + g / 2) Start = 1'b1;
      if (Valid === 1'b1) begin vcnt++; vk = k; end
      if (Valid4 === 1'b1) vcnt4++;
      exp_mode = (g != 0) && (k >= 1) && (k <= SETTLE + g);
      if (Mode !== exp_mode || Mode4 !== exp_mode) mode_ok = 1'b0;
      if (Busy !== (k <= done_k)) busy_ok = 1'b0;
      if (k <= done_k && Stress !== 1'b0) stress_ok = 1'b0;
    end
    // An edge is seen two cycles after RoIn is sampled high following a low sample.
    edges = 0;
    if (g > 0) begin
      for (int c = t0 + SETTLE - 1; c <= t0 + SETTLE + g - 2; c++) begin
        if (ro_hist[c] === 1'b1 && ro_hist[c-1] === 1'b0) edges++;
      end
    end
    exp_vk = (g == 0) ? 2 : SETTLE + g + 2;
    chk("valid pulses", 32'(vcnt), 32'd1);
    chk("valid pulses c4", 32'(vcnt4), 32'd1);
    chk("valid latency", 32'(vk), 32'(exp_vk));
    chk("count", 32'(Count), 32'((edges > MAX24) ? MAX24 : edges));
    chk("overflow", 32'(Overflow), 32'(edges > MAX24));
    chk("count c4", 32'(Count4), 32'((edges > MAX4) ? MAX4 : edges));
    chk("overflow c4", 32'(Overflow4), 32'(edges > MAX4));
    chk("mode window", 32'(mode_ok), 32'd1);
    chk("busy window", 32'(busy_ok), 32'd1);
    chk("stress low while busy", 32'(stress_ok), 32'd1);
  endtask

  initial begin
    int vbad;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk_all_zero("reset");

    // Stress follows StressHold in idle, then drops once a measurement starts.
    StressHold = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle stress", 32'(Stress), 32'd1);
    chk("idle mode", 32'(Mode), 32'd0);
    ro_period = 10;
    run_meas(100, 1'b0);
    chk("period10 count exact", 32'(Count), 32'd10);
    StressHold = 1'b0;

    run_meas(0, 1'b0);

    ro_period = 4;
    run_meas(200, 1'b0);

    ro_period = 0;
    for (int n = 0; n < 8; n++) begin
      run_meas($urandom_range(120, 1), n[0]);
    end
    run_meas(1, 1'b0);

    // Abort mid-measure: no Valid afterwards, then a clean measurement.
    ro_period = 10;
    cur_g = 50;
    @(negedge CLK);
    Start = 1'b1;
    GateCycles = GW'(50);
    @(negedge CLK);
    Start = 1'b0;
    repeat (SETTLE + 10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_all_zero("abort");
    vbad = 0;
    repeat (80) begin
      @(negedge CLK);
      if (Valid === 1'b1 || Valid4 === 1'b1 || Busy === 1'b1) vbad++;
    end
    chk("abort no valid", 32'(vbad), 32'd0);
    run_meas(40, 1'b0);
    chk("post-abort count exact", 32'(Count), 32'd4);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
